// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: decodes the D-stage md class, issues Start/MDSel
// pulses, stalls D / bubbles E while the unit is busy, and tracks watchdog and protocol errors.
module md_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Valid_D,
    input  logic [2:0]       MDOp_D,
    input  logic             Stall_Ext,
    input  logic             Busy,
    output logic             Start,
    output logic [3:0]       MDSel,
    output logic             Stall_D,
    output logic             Flush_E,
    output logic             Timeout,
    output logic             ProtoErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q;
    logic              start_q;
    logic [3:0]        mdsel_q;
    logic [WD_W-1:0]   wdog_q;
    logic              timeout_q;
    logic              protoerr_q;
    logic              first_wait_q;
    logic              first_idle_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic md;
    logic pending;
    logic issue;

    always_comb begin
        md      = Valid_D & (MDOp_D != 3'd0);
        pending = (state_q == ISSUE) | Busy;
        // Op 7 reads HI/LO and never issues; ops 1..6 issue when nothing is outstanding.
        issue   = Valid_D & (MDOp_D != 3'd0) & (MDOp_D != 3'd7) & ~pending & ~Stall_Ext;
        Stall_D = md & pending;
        Flush_E = md & pending;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            mdsel_q      <= 4'd0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
            protoerr_q   <= 1'b0;
            first_wait_q <= 1'b0;
            first_idle_q <= 1'b1;
        end else begin
            first_idle_q <= 1'b0;
            first_wait_q <= 1'b0;
            if (first_idle_q && Busy) begin
                protoerr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        mdsel_q <= {1'b0, MDOp_D};
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    mdsel_q <= 4'd0;
                    wdog_q  <= '0;
                    // mult/div hand over to the unit; mthi/mtlo finish at this edge.
                    if (mdsel_q <= 4'd4) begin
                        state_q      <= WAIT;
                        first_wait_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (Busy) begin
                        if (wdog_q == WD_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end else begin
                        if (first_wait_q) begin
                            protoerr_q <= 1'b1;
                        end
                        if (issue) begin
                            state_q <= ISSUE;
                            start_q <= 1'b1;
                            mdsel_q <= {1'b0, MDOp_D};
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                    mdsel_q <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (Stall_D && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Start      = start_q;
    assign MDSel      = mdsel_q;
    assign Timeout    = timeout_q;
    assign ProtoErr   = protoerr_q;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: decode vector table plus hand-driven Busy sequences,
// with Start/MDSel expectations queued at drive time and checked one edge later.
module tb_md_issue_ctrl;

    logic        CLK;
    logic        Reset;
    logic        Valid_D;
    logic [2:0]  MDOp_D;
    logic        Stall_Ext;
    logic        Busy;
    logic        Start;
    logic [3:0]  MDSel;
    logic        Stall_D;
    logic        Flush_E;
    logic        Timeout;
    logic        ProtoErr;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;
    int base;

    typedef struct {
        logic       start;
        logic [3:0] mdsel;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic       ext;
        logic       busy;
        logic       stall;
        logic       start;
        logic [3:0] mdsel;
    } vec_t;
    vec_t vecs[12];

    md_issue_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Valid_D    (Valid_D),
        .MDOp_D     (MDOp_D),
        .Stall_Ext  (Stall_Ext),
        .Busy       (Busy),
        .Start      (Start),
        .MDSel      (MDSel),
        .Stall_D    (Stall_D),
        .Flush_E    (Flush_E),
        .Timeout    (Timeout),
        .ProtoErr   (ProtoErr),
        .StallCount (StallCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic ext, input logic b);
        Valid_D   = v;
        MDOp_D    = op;
        Stall_Ext = ext;
        Busy      = b;
        #1;
    endtask

    task automatic expect_next(input logic s, input logic [3:0] m);
        sb_t e;
        e.start = s;
        e.mdsel = m;
        sb.push_back(e);
    endtask

    task automatic cyc_sb(input string nm);
        sb_t e;
        cyc();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "_start"}, Start, e.start);
            chk({nm, "_mdsel"}, MDSel, e.mdsel);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5};
        vecs[7]  = '{1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6};
        vecs[11] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};

        // Reset state, with combinational stall still following Busy.
        Reset = 1'b0;
        drive(1'b1, 3'd7, 1'b0, 1'b1);
        chk("rst_start", Start, 1'b0);
        chk("rst_mdsel", MDSel, 4'd0);
        chk("rst_timeout", Timeout, 1'b0);
        chk("rst_protoerr", ProtoErr, 1'b0);
        chk("rst_stallcount", StallCount, 16'd0);
        chk("rst_stall_busy", Stall_D, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        cyc();
        cyc();

        // Decode table from IDLE.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].ext, vecs[i].busy);
            chk($sformatf("vec%0d_stall", i), Stall_D, vecs[i].stall);
            chk($sformatf("vec%0d_flush", i), Flush_E, vecs[i].stall);
            expect_next(vecs[i].start, vecs[i].mdsel);
            cyc_sb($sformatf("vec%0d", i));
            drive(1'b0, 3'd0, 1'b0, 1'b0);
            expect_next(1'b0, 4'd0);
            cyc_sb($sformatf("vec%0d_after", i));
        end
        chk("vec_stallcount", StallCount, 16'd4);

        // mult, Busy 5 cycles, mfhi waiting behind it.
        base = StallCount;
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        chk("mult_nostall", Stall_D, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("mult_issue");
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        chk("mult_mfhi_stall_issue", Stall_D, 1'b1);
        expect_next(1'b0, 4'd0);
        cyc_sb("mult_pulse_end");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd7, 1'b0, 1'b1);
            chk($sformatf("mult_mfhi_stall_busy%0d", i), Stall_D, 1'b1);
            expect_next(1'b0, 4'd0);
            cyc_sb($sformatf("mult_wait%0d", i));
        end
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        chk("mult_mfhi_release", Stall_D, 1'b0);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk("mult_stallcount", StallCount - base, 32'd6);
        chk("mult_timeout", Timeout, 1'b0);
        chk("mult_protoerr", ProtoErr, 1'b0);

        // mtlo then mflo back-to-back.
        base = StallCount;
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        expect_next(1'b1, 4'd6);
        cyc_sb("mtlo_issue");
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        chk("mflo_stall", Stall_D, 1'b1);
        expect_next(1'b0, 4'd0);
        cyc_sb("mtlo_done");
        chk("mflo_proceeds", Stall_D, 1'b0);
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        expect_next(1'b1, 4'd5);
        cyc_sb("mtlo_idle_after");
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("mtlo_stallcount", StallCount - base, 32'd1);

        // div with Busy 10 cycles and a second div waiting in D.
        base = StallCount;
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        expect_next(1'b1, 4'd3);
        cyc_sb("div1_issue");
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        chk("div2_stall_issue", Stall_D, 1'b1);
        expect_next(1'b0, 4'd0);
        cyc_sb("div1_pulse_end");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd3, 1'b0, 1'b1);
            expect_next(1'b0, 4'd0);
            cyc_sb($sformatf("div1_wait%0d", i));
        end
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        chk("div2_release", Stall_D, 1'b0);
        expect_next(1'b1, 4'd3);
        cyc_sb("div2_b2b_issue");
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("div_stallcount", StallCount - base, 32'd11);
        chk("div_protoerr", ProtoErr, 1'b0);

        // Stall_Ext holding off a multu for 3 cycles.
        base = StallCount;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd2, 1'b1, 1'b0);
            chk($sformatf("ext_nostall%0d", i), Stall_D, 1'b0);
            expect_next(1'b0, 4'd0);
            cyc_sb($sformatf("ext_block%0d", i));
        end
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        chk("ext_nostall_drop", Stall_D, 1'b0);
        expect_next(1'b1, 4'd2);
        cyc_sb("ext_multu_issue");
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("ext_stallcount", StallCount - base, 32'd0);

        // Busy never drops: watchdog.
        base = StallCount;
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("wd_issue");
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'd7, 1'b0, 1'b1);
            if (i == 15) chk("wd_timeout_early", Timeout, 1'b0);
            cyc();
        end
        chk("wd_timeout", Timeout, 1'b1);
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        chk("wd_stall_after", Stall_D, 1'b1);
        expect_next(1'b0, 4'd0);
        cyc_sb("wd_no_issue");
        chk("wd_stallcount", StallCount - base, 32'd18);
        chk("wd_protoerr", ProtoErr, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("wd_timeout_sticky", Timeout, 1'b1);

        // Busy never rises after mult Start.
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("pe_issue");
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("pe_before", ProtoErr, 1'b0);
        cyc();
        chk("pe_set", ProtoErr, 1'b1);

        // Reset during WAIT clears immediately.
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("rw_issue");
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 3'd7, 1'b0, 1'b1);
        cyc();
        cyc();
        #2;
        Reset = 1'b0;
        #1;
        chk("rw_start", Start, 1'b0);
        chk("rw_mdsel", MDSel, 4'd0);
        chk("rw_timeout", Timeout, 1'b0);
        chk("rw_protoerr", ProtoErr, 1'b0);
        chk("rw_stallcount", StallCount, 16'd0);
        chk("rw_stall_busy", Stall_D, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        cyc();
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("rw_reissue");
        #2;
        Reset = 1'b0;
        #1;
        chk("ri_start", Start, 1'b0);
        chk("ri_mdsel", MDSel, 4'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        cyc();
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next(1'b1, 4'd1);
        cyc_sb("rw_mult");
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        expect_next(1'b0, 4'd0);
        cyc_sb("rw_mult_end");
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("rw_after_protoerr", ProtoErr, 1'b0);
        chk("rw_after_timeout", Timeout, 1'b0);
        chk("rw_after_stallcount", StallCount, 16'd0);

        // Busy already high in the first IDLE cycle after release.
        Reset = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge CLK);
        Reset = 1'b1;
        cyc();
        chk("first_idle_busy_protoerr", ProtoErr, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
